cmp_window_stats: RTL and testbench
===================================

# cmp_window_stats

Windowed statistics stage downstream of the N-bit magnitude comparator. It accepts one comparator result per cycle: the `lesser`/`greater`/`equal` flags plus the operand pair `a`,`b`. Over a fixed window of WIN accepted samples it counts each outcome, tracks the largest |a−b| and counts malformed flag sets. It then presents one registered report through a valid/ready handshake.

## Interface
- N, 8, operand width (matches comparator width)
- WIN, 16, accepted samples per window; WIN ≥ 1
- CW, $clog2(WIN+1), counter width (derived, not overridden)

- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  sample present
- in_ready  out  1  stage can accept a sample
- a  in  N  comparator operand a (unsigned)
- b  in  N  comparator operand b (unsigned)
- lesser  in  1  comparator flag a<b
- greater  in  1  comparator flag a>b
- equal  in  1  comparator flag a==b
- out_valid  out  1  report available
- out_ready  in  1  consumer takes report
- lt_cnt  out  CW  lesser samples in window
- gt_cnt  out  CW  greater samples in window
- eq_cnt  out  CW  equal samples in window
- err_cnt  out  CW  samples whose flags were not exactly one-hot
- max_diff  out  N  maximum |a−b| over valid (one-hot) samples in window

## Operation
- Two-state FSM: ACCUM, REPORT. Reset state is ACCUM.
- ACCUM:
  - in_ready=1, out_valid=0.
  - Accept occurs when in_valid && in_ready at a rising edge.
  - Each accepted sample increments exactly one of lt_cnt/gt_cnt/eq_cnt/err_cnt, plus sample counter smp_cnt.
  - One-hot flags select the matching counter. Any other combination (000, 110, 111, …) increments err_cnt only and does not update max_diff.
  - max_diff ← max(max_diff, |a−b|) for one-hot samples. |a−b| is computed in N bits as (a≥b ? a−b : b−a). The flags are not trusted for this.
- The accept that brings smp_cnt to WIN transitions ACCUM→REPORT. smp_cnt clears.
- REPORT:
  - in_ready=0, out_valid=1; in_valid is ignored.
  - lt/gt/eq/err_cnt and max_diff are held stable.
  - out_valid && out_ready → ACCUM. All counters and max_diff clear to 0 on that same edge.
- Invariant at report: lt_cnt+gt_cnt+eq_cnt+err_cnt == WIN.
- Outputs are registered. In ACCUM they show running partial values, which are meaningful only while out_valid=1.
- WIN=1: every accept goes straight to REPORT.

## Timing
- Reset values:
  - in_ready=0 during the cycle rst is sampled high; in_ready=1 from the first cycle after rst deasserts.
  - out_valid=0.
  - all counts and max_diff = 0; FSM=ACCUM; smp_cnt=0.
- Latency: a sample accepted at edge k is reflected in counters after edge k. If it is the WIN-th sample, out_valid=1 in the cycle after edge k.
- Report turnaround: handshake at edge m → in_ready=1 and counts=0 in the cycle after m. There is one dead input cycle minimum per window (the REPORT cycle).
- out_valid, once high, stays high with stable data until accepted. There is no timeout.
- in_ready does not depend combinationally on out_ready or in_valid; it is a decode of the FSM state.
- Reset mid-operation (either state) discards the partial window or pending report and returns to reset values on the next edge. rst has priority over every handshake in the same cycle.
- Gaps in in_valid during ACCUM stall accumulation with no state change.

## Test plan
- WIN=4, samples (111,250,L), (147,103,G), (255,255,E), (85,25,G) back-to-back, out_ready=1 → out_valid=1 one cycle after 4th accept; lt=1, gt=2, eq=1, err=0, max_diff=139; next cycle in_ready=1, all counts 0.
- WIN=4, flags 110 on (10,20), 000 on (0,255), then (21,50,L), (96,96,E) → err=2, lt=1, eq=1, max_diff=29 (malformed samples excluded).
- Backpressure: hold out_ready=0 for 5 cycles in REPORT while in_valid=1 with varied data → outputs unchanged, in_ready=0, no counter change; then out_ready=1 → clear next cycle.
- Gapped input: WIN=4, in_valid toggled 1,0,0,1,1,0,1 → report only after the 4th accept; counts match the accepted samples only.
- Reset mid-window after 2 accepts, then 4 new samples (199,220,L)×4 → report lt=4, max_diff=21, no residue from the pre-reset samples; reset asserted in REPORT → out_valid=0 next cycle.
- Extremes: N=8, (0,255,L) and (255,0,G) → max_diff=255; WIN=1 → report after every accept with exactly one count equal to 1.

Source files
------------

// File: rtl/cmp_window_stats.sv
// cmp_window_stats: windowed statistics over comparator results.
// Counts lesser/greater/equal/malformed outcomes and tracks the largest
// |a-b| over WIN accepted samples, then holds one registered report until
// the consumer takes it.
module cmp_window_stats #(
  parameter  int N   = 8,
  parameter  int WIN = 16,
  localparam int CW  = $clog2(WIN + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  a,
  input  logic [N-1:0]  b,
  input  logic          lesser,
  input  logic          greater,
  input  logic          equal,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [CW-1:0] lt_cnt,
  output logic [CW-1:0] gt_cnt,
  output logic [CW-1:0] eq_cnt,
  output logic [CW-1:0] err_cnt,
  output logic [N-1:0]  max_diff
);

  typedef enum logic {ACCUM, REPORT} state_t;

  state_t        state;
  logic [CW-1:0] smp_cnt;
  logic [N-1:0]  diff;
  logic          is_lt;
  logic          is_gt;
  logic          is_eq;
  logic          accept;
  logic          last;

  // Magnitude difference computed from the operands; the flags are not trusted.
  always_comb begin
    diff   = (a >= b) ? (a - b) : (b - a);
    is_lt  = ({lesser, greater, equal} == 3'b100);
    is_gt  = ({lesser, greater, equal} == 3'b010);
    is_eq  = ({lesser, greater, equal} == 3'b001);
    accept = in_valid && in_ready;
    last   = (smp_cnt == CW'(WIN - 1));
  end

  // Window FSM: accumulate WIN accepted samples, then hold the report until taken.
  // in_ready/out_valid are registered copies of the next-state decode.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ACCUM;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      smp_cnt   <= '0;
      lt_cnt    <= '0;
      gt_cnt    <= '0;
      eq_cnt    <= '0;
      err_cnt   <= '0;
      max_diff  <= '0;
    end else begin
      case (state)
        ACCUM: begin
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          if (accept) begin
            if (is_lt) begin
              lt_cnt <= lt_cnt + CW'(1);
            end else if (is_gt) begin
              gt_cnt <= gt_cnt + CW'(1);
            end else if (is_eq) begin
              eq_cnt <= eq_cnt + CW'(1);
            end else begin
              err_cnt <= err_cnt + CW'(1);
            end
            if ((is_lt || is_gt || is_eq) && (diff > max_diff)) begin
              max_diff <= diff;
            end
            if (last) begin
              smp_cnt   <= '0;
              state     <= REPORT;
              in_ready  <= 1'b0;
              out_valid <= 1'b1;
            end else begin
              smp_cnt <= smp_cnt + CW'(1);
            end
          end
        end
        REPORT: begin
          if (out_ready) begin
            state     <= ACCUM;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            lt_cnt    <= '0;
            gt_cnt    <= '0;
            eq_cnt    <= '0;
            err_cnt   <= '0;
            max_diff  <= '0;
          end
        end
        default: begin
          state     <= ACCUM;
          in_ready  <= 1'b0;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cmp_window_stats.sv
// Bench for cmp_window_stats: a WIN=4 instance driven through a report
// scoreboard, plus a WIN=1 instance checked report-by-report.
module tb_cmp_window_stats;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       in_valid, lesser, greater, equal, out_ready;
  logic [7:0] a, b;
  logic       in_ready, out_valid;
  logic [2:0] lt_cnt, gt_cnt, eq_cnt, err_cnt;
  logic [7:0] max_diff;

  logic       iv1, l1, g1, e1, ordy1;
  logic [7:0] a1, b1;
  logic       ir1, ov1;
  logic [0:0] lt1, gt1, eq1, err1;
  logic [7:0] md1;

  cmp_window_stats #(.N(8), .WIN(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .lesser(lesser), .greater(greater), .equal(equal),
    .out_valid(out_valid), .out_ready(out_ready),
    .lt_cnt(lt_cnt), .gt_cnt(gt_cnt), .eq_cnt(eq_cnt), .err_cnt(err_cnt),
    .max_diff(max_diff)
  );

  cmp_window_stats #(.N(8), .WIN(1)) dut_w1 (
    .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(ir1),
    .a(a1), .b(b1), .lesser(l1), .greater(g1), .equal(e1),
    .out_valid(ov1), .out_ready(ordy1),
    .lt_cnt(lt1), .gt_cnt(gt1), .eq_cnt(eq1), .err_cnt(err1),
    .max_diff(md1)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  typedef struct {
    int lt;
    int gt;
    int eq;
    int err;
    int md;
  } rep_t;

  rep_t sb[$];
  rep_t acc = '{0, 0, 0, 0, 0};
  int   acc_n = 0;

  localparam logic [2:0] FL = 3'b100;
  localparam logic [2:0] FG = 3'b010;
  localparam logic [2:0] FE = 3'b001;

  // Present one sample, wait for it to be accepted, fold it into the model.
  task automatic send(input int av, input int bv, input logic [2:0] f);
    int n;
    int d;
    n = 0;
    @(negedge clk);
    in_valid = 1'b1;
    a = av[7:0];
    b = bv[7:0];
    {lesser, greater, equal} = f;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      chk("accept_timeout", 0, 1);
      return;
    end
    @(posedge clk);
    if (f == FL || f == FG || f == FE) begin
      if (f == FL) acc.lt++;
      else if (f == FG) acc.gt++;
      else acc.eq++;
      d = av - bv;
      if (d < 0) d = -d;
      if (d > acc.md) acc.md = d;
    end else begin
      acc.err++;
    end
    acc_n++;
    if (acc_n == 4) begin
      sb.push_back(acc);
      acc   = '{0, 0, 0, 0, 0};
      acc_n = 0;
    end
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
    a = 8'($urandom);
    b = 8'($urandom);
    chk("no_early_report", out_valid, 0);
  endtask

  // Assumes out_ready=1: report visible one cycle after the last accept, cleared the next.
  task automatic finish_window();
    @(negedge clk);
    in_valid = 1'b0;
    chk("ov_latency", out_valid, 1);
    chk("ir_in_report", in_ready, 0);
    @(negedge clk);
    chk("ir_after_take", in_ready, 1);
    chk("ov_after_take", out_valid, 0);
    chk("lt_clr", lt_cnt, 0);
    chk("gt_clr", gt_cnt, 0);
    chk("eq_clr", eq_cnt, 0);
    chk("err_clr", err_cnt, 0);
    chk("md_clr", max_diff, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst      = 1'b1;
    in_valid = 1'b0;
    sb.delete();
    acc   = '{0, 0, 0, 0, 0};
    acc_n = 0;
    @(negedge clk);
    chk("rst_ir", in_ready, 0);
    chk("rst_ov", out_valid, 0);
    chk("rst_lt", lt_cnt, 0);
    chk("rst_gt", gt_cnt, 0);
    chk("rst_md", max_diff, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_ir_after", in_ready, 1);
  endtask

  // Scoreboard: compare the report on the cycle it is handed over.
  always @(negedge clk) begin : mon
    rep_t e;
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_report", 1, 0);
      end else begin
        e = sb.pop_front();
        chk("rep_lt", lt_cnt, e.lt);
        chk("rep_gt", gt_cnt, e.gt);
        chk("rep_eq", eq_cnt, e.eq);
        chk("rep_err", err_cnt, e.err);
        chk("rep_md", max_diff, e.md);
        chk("rep_sum", lt_cnt + gt_cnt + eq_cnt + err_cnt, 4);
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; {lesser, greater, equal} = 3'b000;
    iv1 = 1'b0; ordy1 = 1'b1; a1 = '0; b1 = '0; {l1, g1, e1} = 3'b000;

    repeat (2) @(negedge clk);
    chk("init_ir", in_ready, 0);
    chk("init_ov", out_valid, 0);
    chk("init_lt", lt_cnt, 0);
    chk("init_md", max_diff, 0);
    chk("init_w1_ir", ir1, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("init_ir_after", in_ready, 1);

    // Basic window.
    send(111, 250, FL); send(147, 103, FG); send(255, 255, FE); send(85, 25, FG);
    finish_window();

    // Malformed flags are counted as errors and excluded from max_diff.
    send(10, 20, 3'b110); send(0, 255, 3'b000); send(21, 50, FL); send(96, 96, FE);
    finish_window();

    // Backpressure: report held while in_valid toggles with junk data.
    @(posedge clk); #1 out_ready = 1'b0;
    send(5, 9, FL); send(9, 5, FG); send(7, 7, FE); send(3, 200, FL);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      a = 8'($urandom);
      b = 8'($urandom);
      {lesser, greater, equal} = 3'($urandom);
      chk("bp_ov", out_valid, 1);
      chk("bp_ir", in_ready, 0);
      if (sb.size() == 0) begin
        chk("bp_sb_empty", 0, 1);
      end else begin
        chk("bp_lt", lt_cnt, sb[0].lt);
        chk("bp_gt", gt_cnt, sb[0].gt);
        chk("bp_md", max_diff, sb[0].md);
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk); #1 out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("bp_ir_back", in_ready, 1);
    chk("bp_ov_clr", out_valid, 0);
    chk("bp_lt_clr", lt_cnt, 0);
    chk("bp_md_clr", max_diff, 0);

    // Gapped input: valid pattern 1,0,0,1,1,0,1.
    send(1, 2, FL); idle(); idle(); send(4, 3, FG); send(6, 6, FE); idle(); send(100, 30, FG);
    finish_window();

    // Reset mid-window discards the partial window.
    send(0, 255, FL); send(200, 1, FG);
    do_reset();
    for (int i = 0; i < 4; i++) send(199, 220, FL);
    finish_window();

    // Reset while a report is pending.
    @(posedge clk); #1 out_ready = 1'b0;
    send(1, 1, FE); send(2, 1, FG); send(1, 2, FL); send(9, 9, FE);
    #1 chk("pre_rst_ov", out_valid, 1);
    do_reset();
    chk("post_rst_lt", lt_cnt, 0);
    @(posedge clk); #1 out_ready = 1'b1;

    // Operand extremes.
    send(0, 255, FL); send(255, 0, FG); send(5, 5, FE); send(1, 2, FL);
    finish_window();

    // WIN=1: every accept produces a report with a single count set.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("w1_ir", ir1, 1);
      iv1 = 1'b1;
      a1 = 8'(20 * i + 7);
      b1 = 8'(60 - 10 * i);
      {l1, g1, e1} = (i == 0) ? FL : ((i == 1) ? FG : 3'b011);
      @(negedge clk);
      iv1 = 1'b0;
      chk("w1_ov", ov1, 1);
      chk("w1_ir_rep", ir1, 0);
      chk("w1_lt", lt1, (i == 0) ? 1 : 0);
      chk("w1_gt", gt1, (i == 1) ? 1 : 0);
      chk("w1_err", err1, (i == 2) ? 1 : 0);
      chk("w1_eq", eq1, 0);
      chk("w1_md", md1, (i == 0) ? 53 : ((i == 1) ? 23 : 0));
      @(negedge clk);
      chk("w1_ov_clr", ov1, 0);
      chk("w1_ir_back", ir1, 1);
    end

    repeat (3) @(negedge clk);
    chk("sb_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
